// File: rtl/vga_sync_decoder.sv
// Recovers pixel column/line row, data enable and horizontal lock from raw
// active-low VGA sync inputs, measuring each line against the expected length.
module vga_sync_decoder #(
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       locked,
  output logic       newline_out,
  output logic       newframe_out,
  output logic       lock_err,
  output logic [9:0] line_len
);

  localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_START   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END     = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  LEN_GOOD  = 10'(H_TOTAL);
  localparam logic [2:0]  LOCK_LAST = 3'(LOCK_LINES - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t     state;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic       hfall, vfall, pend, timeout;
  logic [9:0] pcnt, lcnt, meas_len;
  logic [2:0] good_cnt;
  logic       hact, vact;

  always_comb begin
    hfall    = hs_d & ~hs_q;
    vfall    = vs_d & ~vs_q;
    meas_len = (pcnt == '1) ? pcnt : pcnt + 10'd1;
    // Fires on the clock that moves pcnt into saturation, so a later fall
    // at a saturated count is treated as an ordinary search fall.
    timeout  = !hfall && (pcnt == 10'd1022);
    hact     = ({1'b0, pcnt} >= H_START) && ({1'b0, pcnt} <= H_END);
    vact     = ({1'b0, lcnt} >= V_START) && ({1'b0, lcnt} <= V_END);
    x        = hact ? pcnt - H_START[9:0] : '0;
    y        = vact ? lcnt - V_START[9:0] : '0;
    de       = hact & vact & locked;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hs_q         <= 1'b1;
      hs_d         <= 1'b1;
      vs_q         <= 1'b1;
      vs_d         <= 1'b1;
      pcnt         <= '0;
      lcnt         <= '0;
      pend         <= 1'b0;
      line_len     <= '0;
      newline_out  <= 1'b0;
      newframe_out <= 1'b0;
    end else begin
      hs_q         <= hsync_in;
      hs_d         <= hs_q;
      vs_q         <= vsync_in;
      vs_d         <= vs_q;
      newline_out  <= hfall;
      newframe_out <= hfall & (pend | vfall);
      if (hfall) begin
        pcnt     <= '0;
        line_len <= meas_len;
        if (pend | vfall) begin
          lcnt <= '0;
          pend <= 1'b0;
        end else if (lcnt != '1) begin
          lcnt <= lcnt + 10'd1;
        end
      end else begin
        if (pcnt != '1) pcnt <= pcnt + 10'd1;
        if (vfall) pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      if (timeout) begin
        state    <= SEARCH;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else if (hfall) begin
        case (state)
          SEARCH: begin
            state    <= CHECK;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
          CHECK: begin
            if (meas_len == LEN_GOOD) begin
              if (good_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                good_cnt <= '0;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 3'd1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (meas_len != LEN_GOOD) begin
              state    <= CHECK;
              good_cnt <= '0;
              locked   <= 1'b0;
              lock_err <= 1'b1;
            end
          end
          default: begin
            state    <= SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomised line-timing bench: expected per-line results are queued when each
// line is launched and compared when the decoder reports the line start.
module tb_vga_sync_decoder;

  localparam int unsigned H_SYNC     = 96;
  localparam int unsigned H_BP       = 48;
  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned H_TOTAL    = 800;
  localparam int unsigned V_SYNC     = 2;
  localparam int unsigned V_BP       = 6;
  localparam int unsigned V_ACTIVE   = 10;
  localparam int unsigned LOCK_LINES = 4;
  localparam int unsigned X0 = H_SYNC + H_BP;
  localparam int unsigned X1 = X0 + H_ACTIVE - 1;
  localparam int unsigned Y0 = V_SYNC + V_BP;
  localparam int unsigned Y1 = Y0 + V_ACTIVE - 1;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] x, y, line_len;
  logic       de, locked, newline_out, newframe_out, lock_err;

  vga_sync_decoder #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .LOCK_LINES(LOCK_LINES)
  ) dut (
    .Clk(Clk), .Rst(Rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .de(de), .locked(locked), .newline_out(newline_out),
    .newframe_out(newframe_out), .lock_err(lock_err), .line_len(line_len)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          ll_chk;
    int unsigned ll;
    bit          lk;
    bit          err;
    bit          nf;
    int unsigned lcnt;
    int unsigned len;
    int unsigned roff;
  } rec_t;

  rec_t        exp_q[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned stray  = 0;
  bit          mon_en = 1'b0;

  // Reference model: line history and frame position
  int unsigned prev_len  = 0;
  int unsigned run       = 0;
  int unsigned m_lcnt    = 0;
  bit          vlow_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic check_pixel(input rec_t r, input int unsigned off);
    bit hact, vact;
    hact = (off >= X0) && (off <= X1);
    vact = (r.lcnt >= Y0) && (r.lcnt <= Y1);
    chk("pix_de", 32'(de), 32'(hact && vact && r.lk));
    chk("pix_x", 32'(x), hact ? off - X0 : 0);
    chk("pix_y", 32'(y), vact ? r.lcnt - Y0 : 0);
  endtask

  // Launch one line: hsync low for sw clocks, then high to len clocks total.
  task automatic send_line(input int unsigned len, input int unsigned sw, input bit vlow);
    rec_t r;
    int unsigned lim;
    r.ll_chk = (prev_len != 0);
    r.ll     = (prev_len > 1023) ? 1023 : prev_len;
    r.err    = 1'b0;
    if (prev_len == 0 || prev_len >= 1024) begin
      run = 0;
    end else if (prev_len == H_TOTAL) begin
      run++;
    end else begin
      r.err = (run >= LOCK_LINES);
      run   = 0;
    end
    r.lk   = (run >= LOCK_LINES);
    r.nf   = vlow && !vlow_prev;
    m_lcnt = r.nf ? 0 : ((m_lcnt >= 1023) ? 1023 : m_lcnt + 1);
    r.lcnt = m_lcnt;
    r.len  = len;
    lim    = (len < 1000) ? len : 1000;
    r.roff = $urandom_range(lim - 1, 0);
    exp_q.push_back(r);
    for (int i = 0; i < int'(len); i++) begin
      @(negedge Clk);
      hsync_in = (i < int'(sw)) ? 1'b0 : 1'b1;
      vsync_in = !vlow;
    end
    prev_len  = len;
    vlow_prev = vlow;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    mon_en   = 1'b0;
    Rst      = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_line_len", 32'(line_len), 0);
    chk("rst_newline", 32'(newline_out), 0);
    chk("rst_newframe", 32'(newframe_out), 0);
    chk("rst_lock_err", 32'(lock_err), 0);
    Rst = 1'b0;
    exp_q.delete();
    prev_len  = 0;
    run       = 0;
    m_lcnt    = 0;
    vlow_prev = 1'b0;
    repeat (10) @(negedge Clk);
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    rec_t        cur;
    bit          have;
    int unsigned off;
    have = 1'b0;
    off  = 0;
    forever begin
      @(negedge Clk);
      if (Rst || !mon_en) begin
        have = 1'b0;
      end else begin
        if (lock_err && !newline_out) stray++;
        if (newline_out) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL newline_unexpected: got pulse expected none");
            have = 1'b0;
          end else begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            off  = 0;
            if (cur.ll_chk) chk("line_len", 32'(line_len), cur.ll);
            chk("locked", 32'(locked), 32'(cur.lk));
            chk("lock_err", 32'(lock_err), 32'(cur.err));
            chk("newframe", 32'(newframe_out), 32'(cur.nf));
          end
        end else if (have) begin
          off++;
        end
        if (have && off < cur.len &&
            (off == 0 || off == X0 - 1 || off == X0 || off == X1 ||
             off == X1 + 1 || off == cur.roff))
          check_pixel(cur, off);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned len, sw, vrem, pick;
    bit vl;
    do_reset();

    for (int i = 0; i < 22; i++) send_line(800, 96, i < 2);

    send_line(801, 96, 1'b0);
    for (int i = 0; i < 5; i++) send_line(800, 96, 1'b0);

    vrem = 0;
    for (int i = 0; i < 20; i++) begin
      pick = $urandom_range(9, 0);
      case (pick)
        6:       len = 801;
        7:       len = 799;
        8:       len = $urandom_range(900, 700);
        default: len = 800;
      endcase
      sw = $urandom_range(120, 8);
      if (vrem == 0 && $urandom_range(7, 0) == 0) vrem = 2;
      vl = (vrem != 0);
      if (vrem != 0) vrem--;
      send_line(len, sw, vl);
    end

    for (int i = 0; i < 5; i++) send_line(800, 96, 1'b0);
    send_line(96 + 1100, 96, 1'b0);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_x", 32'(x), 0);
    chk("timeout_de", 32'(de), 0);

    for (int i = 0; i < 6; i++) send_line(800, 96, 1'b0);
    send_line(300, 96, 1'b0);
    chk("pre_reset_locked", 32'(locked), 1);
    do_reset();

    for (int i = 0; i < 7; i++) send_line(800, 96, i < 2);
    repeat (5) @(negedge Clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("stray_lock_err", stray, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
